// File: rtl/seg14_scan_capture.sv
// Snoops a 12-digit multiplexed 14-segment display bus, checks scan order and
// decodes each glyph to ASCII; every complete in-order scan lands in a readable frame buffer.
module seg14_scan_capture #(
    parameter int          NDIG     = 12,
    parameter logic [7:0]  UNK_CHAR = 8'h3F
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NDIG-1:0] sel,
    input  logic [13:0]     segm,
    input  logic [3:0]      rd_addr,
    output logic [7:0]      rd_char,
    output logic            frame_valid,
    output logic [7:0]      frame_cnt,
    output logic            locked,
    output logic            err_seq,
    output logic            err_onehot,
    output logic            err_glyph
);

    // state | meaning
    // HUNT  | waiting for digit 0 to start a capture
    // CAP   | capturing; exp_dig is the next digit due (1..11)
    typedef enum logic {HUNT, CAP} state_t;

    localparam logic [3:0] LAST = 4'(NDIG - 1);

    state_t      state, state_n;
    logic [3:0]  exp_dig, exp_dig_n;

    logic [NDIG-1:0] sel_q;
    logic [13:0]     segm_q;
    logic [7:0]      shadow [NDIG];
    logic [7:0]      fbuf   [NDIG];

    logic [7:0] code;
    logic       glyph_ok;
    logic [3:0] dig;
    logic       sel_zero, sel_multi, sel_one;
    logic       wr_shadow, do_commit, seq_err, onehot_err, glyph_err;

    always_comb begin
        code     = UNK_CHAR;
        glyph_ok = 1'b1;
        case (segm_q)
            14'b11101111000000: code = 8'h41;
            14'b10011110000000: code = 8'h45;
            14'b10111101000000: code = 8'h47;
            14'b00011100000000: code = 8'h4C;
            14'b01101100100100: code = 8'h4E;
            14'b11111100000000: code = 8'h4F;
            14'b10010000001001: code = 8'h5A;
            14'b00000000000000: code = 8'h20;
            14'b11111100001001: code = 8'h30;
            14'b01100000001000: code = 8'h31;
            14'b11011011000000: code = 8'h32;
            14'b11110001000000: code = 8'h33;
            14'b01100111000000: code = 8'h34;
            14'b10110111000000: code = 8'h35;
            14'b10111111000000: code = 8'h36;
            14'b11100000000000: code = 8'h37;
            14'b11111111000000: code = 8'h38;
            14'b11110111000000: code = 8'h39;
            default:            glyph_ok = 1'b0;
        endcase
    end

    always_comb begin
        dig = '0;
        for (int k = 0; k < NDIG; k++)
            if (sel_q[k]) dig = 4'(k);
    end

    assign sel_zero  = (sel_q == '0);
    assign sel_multi = ($countones(sel_q) > 1);
    assign sel_one   = !sel_zero && !sel_multi;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HUNT;
            exp_dig <= '0;
        end else begin
            state   <= state_n;
            exp_dig <= exp_dig_n;
        end
    end

    always_comb begin
        state_n   = state;
        exp_dig_n = exp_dig;
        if (sel_multi) begin
            state_n = HUNT;
        end else if (sel_one) begin
            case (state)
                HUNT: begin
                    if (dig == 4'd0) begin
                        state_n   = CAP;
                        exp_dig_n = 4'd1;
                    end
                end
                CAP: begin
                    if (dig == exp_dig) begin
                        if (dig == LAST) state_n = HUNT;
                        else             exp_dig_n = exp_dig + 4'd1;
                    end else if (dig == exp_dig - 4'd1) begin
                        state_n = CAP;
                    end else if (dig == 4'd0) begin
                        exp_dig_n = 4'd1;
                    end else begin
                        state_n = HUNT;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_comb begin
        wr_shadow  = 1'b0;
        do_commit  = 1'b0;
        seq_err    = 1'b0;
        onehot_err = 1'b0;
        glyph_err  = 1'b0;
        if (sel_multi) begin
            onehot_err = 1'b1;
        end else if (sel_one) begin
            case (state)
                HUNT: begin
                    if (dig == 4'd0) begin
                        wr_shadow = 1'b1;
                        glyph_err = !glyph_ok;
                    end
                end
                CAP: begin
                    glyph_err = !glyph_ok;
                    if (dig == exp_dig) begin
                        wr_shadow = 1'b1;
                        do_commit = (dig == LAST);
                    end else if (dig == exp_dig - 4'd1) begin
                        wr_shadow = 1'b1;
                    end else begin
                        seq_err   = 1'b1;
                        wr_shadow = (dig == 4'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    // The last digit's code bypasses the shadow so a commit and the next
    // scan's digit 0 can land on back-to-back edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= '0;
            segm_q      <= '0;
            rd_char     <= '0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
            locked      <= 1'b0;
            err_seq     <= 1'b0;
            err_onehot  <= 1'b0;
            err_glyph   <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                shadow[i] <= 8'h20;
                fbuf[i]   <= 8'h20;
            end
        end else begin
            sel_q  <= sel;
            segm_q <= segm;
            if (wr_shadow) shadow[dig] <= code;
            if (do_commit) begin
                for (int i = 0; i < NDIG; i++)
                    fbuf[i] <= (i == NDIG - 1) ? code : shadow[i];
                frame_cnt <= frame_cnt + 8'd1;
            end
            frame_valid <= do_commit;
            err_seq     <= seq_err;
            err_onehot  <= onehot_err;
            err_glyph   <= glyph_err;
            if (do_commit)                    locked <= 1'b1;
            else if (seq_err || onehot_err)   locked <= 1'b0;
            rd_char <= (rd_addr < 4'(NDIG)) ? fbuf[rd_addr] : 8'h00;
        end
    end

endmodule

// File: tb/tb_seg14_scan_capture.sv
// Bench for seg14_scan_capture: directed scans plus a random phase, all outputs
// compared every cycle against a frame-level reference model.
module tb_seg14_scan_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sel;
    logic [13:0] segm;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_char;
    logic        frame_valid;
    logic [7:0]  frame_cnt;
    logic        locked, err_seq, err_onehot, err_glyph;

    seg14_scan_capture dut (
        .clk(clk), .rst(rst), .sel(sel), .segm(segm), .rd_addr(rd_addr),
        .rd_char(rd_char), .frame_valid(frame_valid), .frame_cnt(frame_cnt),
        .locked(locked), .err_seq(err_seq), .err_onehot(err_onehot),
        .err_glyph(err_glyph)
    );

    always #5 clk = ~clk;

    // A E G L N O Z space 0 1 2 3 4 5 6 7 8 9
    localparam logic [13:0] PATS [18] = '{
        14'b11101111000000, 14'b10011110000000, 14'b10111101000000, 14'b00011100000000,
        14'b01101100100100, 14'b11111100000000, 14'b10010000001001, 14'b00000000000000,
        14'b11111100001001, 14'b01100000001000, 14'b11011011000000, 14'b11110001000000,
        14'b01100111000000, 14'b10110111000000, 14'b10111111000000, 14'b11100000000000,
        14'b11111111000000, 14'b11110111000000};
    localparam logic [7:0] CODES [18] = '{
        8'h41, 8'h45, 8'h47, 8'h4C, 8'h4E, 8'h4F, 8'h5A, 8'h20,
        8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    int vecs = 0;
    int errs = 0;
    int fv_seen = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level bookkeeping on the samples taken one edge earlier.
    bit          mvalid = 0;
    logic [11:0] p_sel;
    logic [13:0] p_segm;
    bit          m_hunt;
    int          m_want;
    logic [7:0]  m_sh [12];
    logic [7:0]  m_buf [12];
    logic [7:0]  m_rd, m_fc;
    bit          m_fv, m_lock, m_es, m_eo, m_eg;

    task automatic model_step();
        int n, d;
        logic [7:0] c;
        bit ok;
        if (rst) begin
            p_sel = 0; p_segm = 0; m_hunt = 1; m_want = 0;
            foreach (m_sh[i]) begin m_sh[i] = 8'h20; m_buf[i] = 8'h20; end
            m_rd = 0; m_fc = 0; m_fv = 0; m_lock = 0; m_es = 0; m_eo = 0; m_eg = 0;
        end else begin
            m_rd = (rd_addr < 12) ? m_buf[rd_addr] : 8'h00;
            m_fv = 0; m_es = 0; m_eo = 0; m_eg = 0;
            n = $countones(p_sel);
            if (n > 1) begin
                m_eo = 1; m_lock = 0; m_hunt = 1;
            end else if (n == 1) begin
                d = 0;
                for (int k = 0; k < 12; k++) if (p_sel[k]) d = k;
                c = 8'h3F; ok = 0;
                for (int k = 0; k < 18; k++)
                    if (PATS[k] == p_segm) begin c = CODES[k]; ok = 1; end
                if (m_hunt) begin
                    if (d == 0) begin
                        m_sh[0] = c; m_want = 1; m_hunt = 0; m_eg = !ok;
                    end
                end else begin
                    m_eg = !ok;
                    if (d == m_want) begin
                        m_sh[d] = c;
                        if (d == 11) begin
                            m_buf = m_sh; m_fv = 1; m_fc = m_fc + 8'd1; m_lock = 1; m_hunt = 1;
                        end else m_want++;
                    end else if (d == m_want - 1) begin
                        m_sh[d] = c;
                    end else begin
                        m_es = 1; m_lock = 0;
                        if (d == 0) begin m_sh[0] = c; m_want = 1; end
                        else m_hunt = 1;
                    end
                end
            end
            p_sel = sel; p_segm = segm;
        end
        mvalid = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (mvalid) begin
            chk("rd_char", rd_char, m_rd);
            chk("frame_valid", frame_valid, m_fv);
            chk("frame_cnt", frame_cnt, m_fc);
            chk("locked", locked, m_lock);
            chk("err_seq", err_seq, m_es);
            chk("err_onehot", err_onehot, m_eo);
            chk("err_glyph", err_glyph, m_eg);
            if (frame_valid) fv_seen++;
        end
    end

    int txt [12];
    int bad_dig = -1;

    task automatic tick(input logic [11:0] s, input logic [13:0] g, input logic [3:0] a);
        sel = s; segm = g; rd_addr = a;
        @(negedge clk);
    endtask

    task automatic full_scan();
        for (int d = 0; d < 12; d++)
            tick(12'h1 << d, (d == bad_dig) ? 14'h3FFF : PATS[txt[d]], 4'($urandom_range(15)));
    endtask

    initial begin
        int r, nd;
        logic [11:0] s;
        logic [13:0] g;
        rst = 1; sel = 0; segm = 0; rd_addr = 0;
        @(negedge clk);
        repeat (3) tick(0, 0, 0);
        chk("rst_rd_char", rd_char, 8'h00);
        chk("rst_frame_cnt", frame_cnt, 8'h00);
        chk("rst_locked", locked, 1'b0);
        rst = 0;

        // G O N Z A L E + five spaces
        txt = '{2, 5, 4, 6, 0, 3, 1, 7, 7, 7, 7, 7};
        full_scan();
        chk("fv_not_early", frame_valid, 1'b0);
        tick(0, 0, 0);
        chk("fv_two_clks", frame_valid, 1'b1);
        chk("cnt_first", frame_cnt, 8'd1);
        chk("locked_first", locked, 1'b1);
        tick(0, 0, 4'd0);  chk("rd0_G", rd_char, 8'h47);
        tick(0, 0, 4'd4);  chk("rd4_A", rd_char, 8'h41);
        tick(0, 0, 4'd6);  chk("rd6_E", rd_char, 8'h45);
        tick(0, 0, 4'd11); chk("rd11_sp", rd_char, 8'h20);
        tick(0, 0, 4'd13); chk("rd13_zero", rd_char, 8'h00);

        for (int d = 5; d < 12; d++) tick(12'h1 << d, PATS[txt[d]], 0);
        full_scan();
        tick(0, 0, 0);
        chk("cnt_midscan", frame_cnt, 8'd2);

        tick(12'h001, PATS[8], 0); tick(12'h002, PATS[9], 0); tick(12'h004, PATS[10], 0);
        tick(12'h020, PATS[13], 0);
        tick(0, 0, 0);
        chk("seq_pulse", err_seq, 1'b1);
        chk("seq_unlock", locked, 1'b0);
        tick(0, 0, 4'd0); chk("seq_buf_kept", rd_char, 8'h47);

        txt = '{8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 0, 1};
        full_scan();
        tick(0, 0, 0);
        chk("cnt_after_seq", frame_cnt, 8'd3);

        tick(12'h001, PATS[2], 0); tick(12'h002, PATS[5], 0);
        tick(12'h003, PATS[4], 0);
        tick(0, 0, 0);
        chk("onehot_pulse", err_onehot, 1'b1);
        tick(0, 0, 4'd0); chk("onehot_buf_kept", rd_char, 8'h30);

        txt = '{2, 5, 4, 6, 0, 3, 1, 7, 7, 7, 7, 7};
        bad_dig = 3;
        full_scan();
        bad_dig = -1;
        tick(0, 0, 0);
        chk("glyph_commit", frame_valid, 1'b1);
        tick(0, 0, 4'd3); chk("rd3_unk", rd_char, 8'h3F);
        chk("glyph_locked", locked, 1'b1);

        for (int d = 0; d < 6; d++) tick(12'h1 << d, PATS[txt[d]], 0);
        rst = 1; tick(0, 0, 0); rst = 0;
        tick(0, 0, 4'd0); chk("rst_buf_space", rd_char, 8'h20);
        chk("rst_no_fv", frame_valid, 1'b0);
        full_scan();
        tick(0, 0, 0);
        chk("cnt_after_rst", frame_cnt, 8'd1);

        rst = 1; tick(0, 0, 0); rst = 0;
        fv_seen = 0;
        repeat (256) full_scan();
        tick(0, 0, 0); tick(0, 0, 0);
        chk("wrap_pulses", fv_seen[15:0], 16'd256);
        chk("wrap_cnt", frame_cnt, 8'd0);

        nd = 0;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(99);
            if (r < 65) begin s = 12'h1 << nd; nd = (nd + 1) % 12; end
            else if (r < 75) s = 0;
            else if (r < 82) s = 12'h1 << ((nd + 11) % 12);
            else if (r < 90) s = 12'h1 << $urandom_range(11);
            else if (r < 95) s = 12'($urandom);
            else begin s = 12'h001; nd = 1; end
            g = ($urandom_range(99) < 85) ? PATS[$urandom_range(17)] : 14'($urandom);
            rst = ($urandom_range(999) < 3);
            tick(s, g, 4'($urandom_range(15)));
        end
        rst = 0;
        tick(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/seg14_scan_capture.md
Name: seg14_scan_capture

Overview:
Receive-side companion to the 12-digit multiplexed 14-segment display driver. Snoops the driver's one-hot digit select and segment bus, checks scan order, and decodes each 14-bit glyph to an 8-bit ASCII code. Each complete in-order 12-digit scan is committed to a readable frame buffer. Used on-chip for display self-check and for exporting the displayed text to logic-side consumers.

Parameters:
NDIG, 12, number of digits/sel width (fixed at 12 in this revision; addr width 4)
UNK_CHAR, 8'h3F, code stored for an unrecognised glyph ('?')

Ports:
clk  input  1  system clock, same domain as display driver
rst  input  1  synchronous, active-high reset
sel  input  12  digit select from driver; bit k = digit k
segm  input  14  segment pattern from driver
rd_addr  input  4  frame buffer read address (0..11)
rd_char  output  8  committed ASCII char at rd_addr, registered
frame_valid  output  1  one-cycle pulse: new frame committed
frame_cnt  output  8  committed-frame counter, wraps 255->0
locked  output  1  high after a good commit; cleared by any seq/onehot error
err_seq  output  1  one-cycle pulse: out-of-order digit
err_onehot  output  1  one-cycle pulse: sel has >1 bit set
err_glyph  output  1  one-cycle pulse: unrecognised segm pattern

Behaviour:
- Stage 0: sel/segm registered every edge (sel_q, segm_q). Stage 1: FSM and decode act on sel_q/segm_q. Digit-to-action latency is 1 clock after sampling.
- Decode table (segm -> code), exact match only:
  - A 11101111000000->41, E 10011110000000->45, G 10111101000000->47, L 00011100000000->4C
  - N 01101100100100->4E, O 11111100000000->4F, Z 10010000001001->5A, space 0->20
  - 0 11111100001001->30, 1 01100000001000->31, 2 11011011000000->32, 3 11110001000000->33
  - 4 01100111000000->34, 5 10110111000000->35, 6 10111111000000->36, 7 11100000000000->37
  - 8 11111111000000->38, 9 11110111000000->39
  - Any other value -> UNK_CHAR, plus err_glyph pulse (only when sel_q is a valid one-hot in CAP, or digit 0 in HUNT).
- sel_q classification: zero (gap), one-hot (digit d = bit index), multi-hot.
- FSM states: HUNT, CAP (with expect 1..11).
  - Zero sel_q: ignored in both states, no state change.
  - Multi-hot: err_onehot pulse, locked<=0, state<=HUNT, shadow discarded.
  - HUNT: d==0 -> shadow[0]<=code, expect<=1, CAP. d!=0 -> ignored, no error (mid-scan start).
  - CAP, d==expect: shadow[d]<=code. If d==11: commit shadow to frame buffer, frame_valid<=1 next cycle, frame_cnt++, locked<=1, state<=HUNT. Else expect++.
  - CAP, d==expect-1: repeat (slow scan); shadow[d] rewritten, no error.
  - CAP, other d: err_seq pulse, locked<=0. If d==0, restart capture (shadow[0] written, expect<=1). Else state<=HUNT.
- Digit 11 commit and digit 0 restart on consecutive samples must both take effect; no lost frame at full scan rate.
- Unknown glyph does not abort the frame; it commits with UNK_CHAR in that slot.
- Read port: rd_char<=buf[rd_addr] each edge. rd_addr>=12 returns 8'h00. Read in the frame_valid cycle returns new data one edge later.
- Reset: state HUNT, expect 0, buffer and shadow all 8'h20, sel_q/segm_q 0, rd_char 0, frame_cnt 0, locked 0, all pulses 0. Reset mid-frame discards the partial shadow; the buffer reverts to spaces.

Test Plan:
- Scan digits 0..11 with G,O,N,Z,A,L,E, then five spaces, one per clk -> frame_valid single pulse 2 clks after digit 11 is driven; rd_addr 0/4/6/11 -> 47/41/45/20; frame_cnt=1; locked=1; no err pulses.
- Start mid-scan at digit 5, then one full scan -> no errors before digit 0, exactly one frame_valid, frame_cnt=1.
- Digits 0,1,2,5 -> err_seq pulse at digit 5, locked=0, no frame_valid, buffer unchanged; next full scan commits normally.
- sel=12'h003 during CAP -> err_onehot pulse, HUNT; buffer unchanged.
- segm=14'h3FFF on digit 3 of a full scan -> err_glyph pulse, frame commits, rd_addr 3 -> 3F, locked=1.
- rst asserted after digit 5, then released and one full scan -> no frame_valid before reset; buffer reads 20 during the gap; frame_cnt=1 after the scan; 256 back-to-back scans -> frame_cnt wraps to 0 with 256 pulses.
